// File: rtl/mux_scan_ctrl_pkg.sv
// rtl/mux_scan_ctrl_pkg.sv - shared types and constants for the mux scanner
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - frame output handshake bundle of the mux scanner
//
// Signals:
//   frame_data  [4*BITS] : deserialised frame, channel k at [k*BITS +: BITS]
//   frame_valid          : frame available
//   frame_ready          : consumer accepts the frame
//   frame_par   [4]      : per-channel XOR parity (only with MUX_SCAN_PARITY_EN)
// Modports: master (scanner side), slave (consumer side).
interface mux_scan_ctrl_if #(
    parameter int BITS = 8
);
    logic [4*BITS-1:0] frame_data;
    logic              frame_valid;
    logic              frame_ready;
`ifdef MUX_SCAN_PARITY_EN
    logic [3:0]        frame_par;
`endif

    modport master (
        output frame_data,
        output frame_valid,
`ifdef MUX_SCAN_PARITY_EN
        output frame_par,
`endif
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
`ifdef MUX_SCAN_PARITY_EN
        input  frame_par,
`endif
        output frame_ready
    );
endinterface

// File: rtl/mux_scan_chreg.sv
// rtl/mux_scan_chreg.sv - per-channel shadow shift register
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over shift)
//   shift_en   : shift left by one, din enters at the LSB
//   din        : serial sample
//   q          : current shadow contents
module mux_scan_chreg #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            shift_en,
    input  logic            din,
    output logic [BITS-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[BITS-2:0], din};
        end
    end

endmodule

// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - time-division scanner driving a 4-to-1 mux select and deserialising its output
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : scan enable
//   s1, s0     : registered mux select, always equal to the channel counter
//   y          : mux output, sampled on the edge that ends the cycle it is selected
//   bus        : frame handshake (mux_scan_ctrl_if.master)
// Optional feature macro: MUX_SCAN_PARITY_EN adds bus.frame_par.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic            s1,
    output logic            s0,
    input  logic            y,
    mux_scan_ctrl_if.master bus
);

    localparam int BC_W = $clog2(BITS);

    state_t             state;
    logic [CH_W-1:0]    ch;
    logic [BC_W-1:0]    bc;
    logic [BITS-1:0]    sh [NUM_CH];
    logic [NUM_CH-1:0]  shift_en;
    logic               clr;
    logic               last;
    logic               slot_free;
    logic [4*BITS-1:0]  load_data;
`ifdef MUX_SCAN_PARITY_EN
    logic [3:0]         load_par;
`endif

    assign {s1, s0} = ch;

    // Shadow is flushed whenever the scanner is idle or a scan is aborted,
    // so a restarted frame never carries samples of the abandoned one.
    assign clr       = (state == IDLE) || (state == SCAN && !en);
    assign last      = (state == SCAN) && en && (ch == CH_W'(NUM_CH - 1)) && (bc == BC_W'(BITS - 1));
    assign slot_free = !bus.frame_valid || bus.frame_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign shift_en[c] = (state == SCAN) && en && (ch == CH_W'(c));

        mux_scan_chreg #(.BITS(BITS)) u_chreg (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .shift_en (shift_en[c]),
            .din      (y),
            .q        (sh[c])
        );
    end

    // On the completing SCAN edge channel 3's last sample is still on y,
    // so it is merged here; in HOLD the shadow is already complete.
    always_comb begin
        load_data = {sh[3], sh[2], sh[1], sh[0]};
        if (state == SCAN) begin
            load_data[3*BITS +: BITS] = {sh[3][BITS-2:0], y};
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_comb begin
        load_par = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            load_par[c] = ^load_data[c*BITS +: BITS];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ch              <= '0;
            bc              <= '0;
            bus.frame_data  <= '0;
            bus.frame_valid <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            bus.frame_par   <= '0;
`endif
        end else begin
            // Consumer handshake; a frame load below takes precedence.
            if (bus.frame_ready) begin
                bus.frame_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    ch <= '0;
                    bc <= '0;
                    if (en) begin
                        state <= SCAN;
                    end
                end

                SCAN: begin
                    if (!en) begin
                        state <= IDLE;
                        ch    <= '0;
                        bc    <= '0;
                    end else if (last) begin
                        ch <= '0;
                        bc <= '0;
                        if (slot_free) begin
                            bus.frame_data  <= load_data;
                            bus.frame_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                            bus.frame_par   <= load_par;
`endif
                        end else begin
                            state <= HOLD;
                        end
                    end else begin
                        ch <= ch + CH_W'(1);
                        if (ch == CH_W'(NUM_CH - 1)) begin
                            bc <= bc + BC_W'(1);
                        end
                    end
                end

                HOLD: begin
                    if (slot_free) begin
                        bus.frame_data  <= load_data;
                        bus.frame_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                        bus.frame_par   <= load_par;
`endif
                        state <= en ? SCAN : IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    ch    <= '0;
                    bc    <= '0;
                end
            endcase
        end
    end

endmodule
